// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end.
// Owns the fetch PC and drives a 1-cycle-latency instruction ROM.
// Returned words are buffered with their PC in a small FIFO.
// The decode stage drains the FIFO over a valid/ready handshake.
// A redirect flushes every buffered and in-flight fetch.
module fetch_queue #(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  output logic                  ireq,
  output logic [ADDR_WIDTH-1:0] iaddr,
  input  logic [SIZE-1:0]       idata,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH+1:0] redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [SIZE-1:0]       inst,
  output logic [ADDR_WIDTH+1:0] inst_pc
);

  localparam int PCW  = ADDR_WIDTH + 2;
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  localparam logic [CNTW:0]    DEPTH_C       = (CNTW + 1)'(DEPTH);
  localparam logic [PCW-1:0]   PC_STEP       = PCW'(4);
  localparam logic [PCW-1:0]   PC_ALIGN_MASK = ~(PCW'(3));
  localparam logic [PTRW-1:0]  PTR_ONE       = PTRW'(1);
  localparam logic [CNTW-1:0]  CNT_ONE       = CNTW'(1);

  // Fetch state
  logic [PCW-1:0]  fpc_r;
  logic            inflight_r;
  logic [PCW-1:0]  inflight_pc_r;

  // FIFO state
  logic [PTRW-1:0] wr_ptr_r;
  logic [PTRW-1:0] rd_ptr_r;
  logic [CNTW-1:0] count_r;
  logic [SIZE-1:0] data_mem_r [DEPTH];
  logic [PCW-1:0]  pc_mem_r   [DEPTH];

  // Handshake / control
  logic [CNTW:0]   credit_s;
  logic            issue_s;
  logic            push_s;
  logic            pop_s;

  // Buffered entries plus the one in flight must fit in the FIFO; a pop in the
  // same cycle is deliberately not credited, which keeps the check simple and
  // still guarantees the FIFO can never overflow.
  assign credit_s   = {1'b0, count_r} + {{CNTW{1'b0}}, inflight_r};
  assign issue_s    = RESET_N & ~redirect & (credit_s < DEPTH_C);
  assign push_s     = inflight_r & ~redirect;
  assign pop_s      = inst_valid & inst_ready;

  assign ireq       = issue_s;
  assign iaddr      = fpc_r[PCW-1:2];
  assign inst_valid = (count_r != {CNTW{1'b0}}) & ~redirect;
  assign inst       = data_mem_r[rd_ptr_r];
  assign inst_pc    = pc_mem_r[rd_ptr_r];

  // Fetch PC and in-flight tracking; redirect overrides any issue.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fpc_r         <= {PCW{1'b0}};
      inflight_r    <= 1'b0;
      inflight_pc_r <= {PCW{1'b0}};
    end else if (redirect) begin
      fpc_r         <= redirect_pc & PC_ALIGN_MASK;
      inflight_r    <= 1'b0;
    end else if (issue_s) begin
      inflight_r    <= 1'b1;
      inflight_pc_r <= fpc_r;
      fpc_r         <= fpc_r + PC_STEP;
    end else begin
      inflight_r    <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; redirect empties the queue.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_r <= {PTRW{1'b0}};
      rd_ptr_r <= {PTRW{1'b0}};
      count_r  <= {CNTW{1'b0}};
    end else if (redirect) begin
      wr_ptr_r <= {PTRW{1'b0}};
      rd_ptr_r <= {PTRW{1'b0}};
      count_r  <= {CNTW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; cleared on reset so the head outputs read as zero.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_r[i] <= {SIZE{1'b0}};
        pc_mem_r[i]   <= {PCW{1'b0}};
      end
    end else if (push_s) begin
      data_mem_r[wr_ptr_r] <= idata;
      pc_mem_r[wr_ptr_r]   <= inflight_pc_r;
    end
  end

endmodule
